// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte requesters.
// An owner keeps the line across a multi-byte frame until its last byte or a lock timeout.
// Ports:
//   clk, reset       clock and synchronous active-low reset
//   req              per-requester byte valid, held until ack
//   req_data         packed request bytes, requester i at [i*NB_DATA +: NB_DATA]
//   req_last         per-requester end-of-frame flag
//   ack              one-hot single-cycle byte-accepted pulse
//   tx_start         single-cycle start pulse to the serializer
//   tx_data          byte presented to the serializer, held until the next grant
//   tx_done_tick     serializer done pulse
//   busy             high whenever the arbiter is not idle
//   owner            index of the current or last granted requester
module uart_tx_arbiter #(
  parameter int unsigned NB_DATA      = 8,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NB_DATA-1:0]      req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            tx_start,
  output logic [NB_DATA-1:0]              tx_data,
  input  logic                            tx_done_tick,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      owner
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [NUM_REQ-1:0]   ack_n;
  logic                 tx_start_n;
  logic [NB_DATA-1:0]   tx_data_n;
  logic [OW-1:0]        owner_n;
  logic [OW-1:0]        rr_ptr, rr_ptr_n;
  logic [TW-1:0]        timer, timer_n;
  logic                 last_reg, last_n;
  logic                 grant;
  logic [OW-1:0]        win;
  logic [OW-1:0]        owner_inc;

  // First requester at or above the pointer, wrapping modulo NUM_REQ.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0] p);
    logic [OW-1:0] sel;
    logic          found;
    int unsigned   idx;
    sel   = p;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(p) + i) % NUM_REQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        sel   = OW'(idx);
      end
    end
    return sel;
  endfunction

  assign owner_inc = (32'(owner) == NUM_REQ - 1) ? '0 : owner + OW'(1);
  assign busy      = (state != IDLE);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      timer    <= '0;
      last_reg <= 1'b0;
    end else begin
      state    <= state_n;
      ack      <= ack_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      timer    <= timer_n;
      last_reg <= last_n;
    end
  end

  // Next-state and grant decision.
  always_comb begin
    state_n    = state;
    ack_n      = '0;
    tx_start_n = 1'b0;
    tx_data_n  = tx_data;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    timer_n    = timer;
    last_n     = last_reg;
    grant      = 1'b0;
    win        = owner;

    case (state)
      IDLE: begin
        if (|req) begin
          grant = 1'b1;
          win   = rr_pick(req, rr_ptr);
        end
      end
      WAIT_DONE: begin
        if (tx_done_tick) begin
          if (last_reg) begin
            rr_ptr_n = owner_inc;
            state_n  = IDLE;
          end else begin
            timer_n = '0;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (req[owner]) begin
          grant = 1'b1;
          win   = owner;
        end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          rr_ptr_n = owner_inc;
          state_n  = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (grant) begin
      tx_data_n  = req_data[32'(win)*NB_DATA +: NB_DATA];
      tx_start_n = 1'b1;
      ack_n[win] = 1'b1;
      owner_n    = win;
      last_n     = req_last[win];
      state_n    = WAIT_DONE;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single uart_tx serializer between NUM_REQ byte requesters using round-robin arbitration. It drives the serializer's start pulse and parallel data, then waits for the serializer's done pulse before granting the line again. A requester can hold the line across a multi-byte frame by keeping `last` low. Ownership is released on the last byte, or after a lock timeout.

Parameters:
- NB_DATA, 8, byte width; must match the uart_tx NB_DATA.
- NUM_REQ, 4, number of requesters; must be at least 2.
- LOCK_TIMEOUT, 1024, idle cycles an owner may hold the line between frame bytes before forced release; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low; reset==0 asserts it on the rising edge of clk.
- req  in  NUM_REQ  per-requester byte-valid; held high with data/last stable until the matching ack.
- req_data  in  NUM_REQ*NB_DATA  packed bytes; requester i occupies bits [i*NB_DATA +: NB_DATA].
- req_last  in  NUM_REQ  per-requester flag: 1 = this byte ends the frame.
- ack  out  NUM_REQ  one-hot, 1-cycle pulse: byte accepted. Requester may change data or drop req the next cycle.
- tx_start  out  1  1-cycle start pulse to uart_tx `tx`.
- tx_data  out  NB_DATA  byte to uart_tx `data_in`; registered and held until the next grant.
- tx_done_tick  in  1  done pulse from uart_tx.
- busy  out  1  high whenever state is not IDLE.
- owner  out  clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset values: state=IDLE; ack=0; tx_start=0; tx_data=0; owner=0; rr pointer=0; lock timer=0; busy=0.
- All outputs are registered. busy is decoded directly from the state register.
- States:
  - IDLE.
  - WAIT_DONE: byte handed to the serializer.
  - HOLD: frame open, waiting for the owner's next byte.
- Grant action (same edge for all effects):
  - tx_data <= winner's byte.
  - tx_start <= 1 and ack[winner] <= 1, both for exactly one cycle.
  - owner <= winner; last_reg <= req_last[winner]; state <= WAIT_DONE.
- IDLE:
  - If any req is high, the winner is the first set bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - Grant latency: req sampled high at edge N gives tx_start/ack high in cycle N+1.
  - No req: remain in IDLE.
- WAIT_DONE:
  - req is ignored, including the owner's.
  - On tx_done_tick with last_reg=1: rr pointer <= owner+1 (wrapping), state <= IDLE.
  - On tx_done_tick with last_reg=0: state <= HOLD, timer <= 0.
- HOLD:
  - Only req[owner] is considered; other requesters are starved until release.
  - req[owner]=1: grant owner immediately (same grant action as above). The timer is not incremented.
  - Otherwise timer increments each cycle.
  - When timer reaches LOCK_TIMEOUT-1 with no req[owner]: rr pointer <= owner+1, state <= IDLE.
- Re-arbitration gaps:
  - After release, the earliest next tx_start is 2 cycles after tx_done_tick: one edge to IDLE, one edge to grant.
  - In HOLD the gap is the same 2 cycles if req[owner] is already high.
- tx_done_tick in IDLE or HOLD is ignored (spurious pulse).
- The serializer samples `tx` only in its own IDLE state. tx_start is issued only after its done pulse, so no start is lost.
- req dropped before ack: the request is withdrawn with no side effects. A req that disappears in the same edge it would win is not granted, because arbitration uses the sampled value.
- Reset mid-frame: all state is cleared on the next edge, with no ack or tx_start. uart_tx shares the reset, so the line returns to idle-high.
- A single requester with last=1 on every byte gets back-to-back grants. Each grant passes through IDLE.

Test Plan:
1. Reset, then req=4'b0001, data0=8'hA5, last=1 → tx_start and ack=4'b0001 one cycle later, tx_data=8'hA5. On tx_done_tick: busy falls next cycle, rr pointer=1.
2. req=4'b1111 held, all last=1, all bytes distinct → grant order 0,1,2,3,0, each after one tx_done_tick. No two ack bits are ever set together.
3. Requester 2 sends 3 bytes 8'h11, 8'h22, 8'h33 (last on the third) while req[0] is held high → serial order 11, 22, 33, then requester 0's byte. ack[0] stays low until the frame ends.
4. Requester 1 sends byte with last=0, then goes silent; LOCK_TIMEOUT=8 → release exactly 8 cycles after entering HOLD. A pending req[3] is granted on the following cycle.
5. Pulse tx_done_tick while in IDLE and while in HOLD → no state change and no ack. Drop req[0] one cycle before its grant edge → no grant.
6. Assert reset=0 during WAIT_DONE and during HOLD → the next cycle shows all outputs at reset values. After release, a new req is granted starting from requester 0.
